// File: rtl/math_pkg.sv
`default_nettype none
// ============================================================================
// Package  : math_pkg
// Purpose  : Shared opcodes, state encoding and operand field layout.
// Revision : 1.0
// ============================================================================
package math_pkg;

    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Operand layout on the 64-bit bus: {A,B,C,D}, A in the top lane.
    localparam int FIELD_W = 16;
    localparam int A_LSB   = 48;
    localparam int B_LSB   = 32;
    localparam int C_LSB   = 16;
    localparam int D_LSB   = 0;

    function automatic logic [FIELD_W-1:0] get_field(input logic [63:0] data, input int lsb);
        return data[lsb +: FIELD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/math_unit_ctrl_math_unit.sv
`default_nettype none
// ============================================================================
// Module   : math_unit
// Purpose  : Combinational signed MUL/DIV, simple (two lanes) or complex mode.
// Revision : 1.0
// ============================================================================
module math_unit
    import math_pkg::*;
(
    input  logic        i_mode,
    input  logic [3:0]  i_op,
    input  logic [63:0] i_data,
    output logic [31:0] o_out1,
    output logic [31:0] o_out2
);

    logic signed [15:0] w_a, w_b, w_c, w_d;
    logic signed [33:0] w_num_re, w_num_im, w_den;

    assign w_a = get_field(i_data, A_LSB);
    assign w_b = get_field(i_data, B_LSB);
    assign w_c = get_field(i_data, C_LSB);
    assign w_d = get_field(i_data, D_LSB);

    // (A+jB)/(C+jD) = ((AC+BD) + j(BC-AD)) / (C^2+D^2)
    assign w_num_re = 34'(w_a) * 34'(w_c) + 34'(w_b) * 34'(w_d);
    assign w_num_im = 34'(w_b) * 34'(w_c) - 34'(w_a) * 34'(w_d);
    assign w_den    = 34'(w_c) * 34'(w_c) + 34'(w_d) * 34'(w_d);

    always_comb begin
        o_out1 = '0;
        o_out2 = '0;
        case (i_op)
            OP_MUL: begin
                if (i_mode) begin
                    o_out1 = 32'(w_a) * 32'(w_c) - 32'(w_b) * 32'(w_d);
                    o_out2 = 32'(w_a) * 32'(w_d) + 32'(w_b) * 32'(w_c);
                end else begin
                    o_out1 = 32'(w_a) * 32'(w_b);
                    o_out2 = 32'(w_c) * 32'(w_d);
                end
            end
            OP_DIV: begin
                if (i_mode) begin
                    o_out1 = 32'(w_num_re / w_den);
                    o_out2 = 32'(w_num_im / w_den);
                end else begin
                    o_out1 = 32'(w_a) / 32'(w_b);
                    o_out2 = 32'(w_c) / 32'(w_d);
                end
            end
            default: begin
                o_out1 = '0;
                o_out2 = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/math_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : math_unit_ctrl
// Purpose  : Two-port round-robin sequencer for math_unit with a registered
//            valid/ready result. Option: MATH_CTRL_DIVZERO_CHK_EN.
// Revision : 1.0
// ============================================================================
module math_unit_ctrl
    import math_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic        i_mode0,
    input  logic [3:0]  i_op0,
    input  logic [63:0] i_data0,
    input  logic        i_req1,
    input  logic        i_mode1,
    input  logic [3:0]  i_op1,
    input  logic [63:0] i_data1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_busy,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic        o_res_id,
    output logic [31:0] o_res_out1,
    output logic [31:0] o_res_out2,
    output logic        o_res_err
);

    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_LAT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rr;
    logic              r_mode;
    logic [3:0]        r_op;
    logic [63:0]       r_data;
    logic              r_id;
    logic              r_gnt0, r_gnt1, r_valid, r_err;
    logic [31:0]       r_out1, r_out2;

    logic              w_any_req, w_win, w_sel_mode, w_invalid, w_div_zero, w_bypass;
    logic [3:0]        w_sel_op;
    logic [63:0]       w_sel_data;
    logic [31:0]       w_mu_out1, w_mu_out2;

    assign w_any_req  = i_req0 | i_req1;
    assign w_win      = (i_req0 & i_req1) ? r_rr : i_req1;
    assign w_sel_mode = w_win ? i_mode1 : i_mode0;
    assign w_sel_op   = w_win ? i_op1   : i_op0;
    assign w_sel_data = w_win ? i_data1 : i_data0;
    assign w_invalid  = (w_sel_op != OP_MUL) && (w_sel_op != OP_DIV);

`ifdef MATH_CTRL_DIVZERO_CHK_EN
    logic w_b_zero, w_c_zero, w_d_zero;
    assign w_b_zero   = (get_field(w_sel_data, B_LSB) == '0);
    assign w_c_zero   = (get_field(w_sel_data, C_LSB) == '0);
    assign w_d_zero   = (get_field(w_sel_data, D_LSB) == '0);
    assign w_div_zero = (w_sel_op == OP_DIV) &&
                        (w_sel_mode ? (w_c_zero && w_d_zero) : (w_b_zero || w_d_zero));
`else
    assign w_div_zero = 1'b0;
`endif

    assign w_bypass = w_invalid | w_div_zero;

    math_unit u_math_unit (
        .i_mode (r_mode),
        .i_op   (r_op),
        .i_data (r_data),
        .o_out1 (w_mu_out1),
        .o_out2 (w_mu_out2)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rr    <= 1'b0;
            r_mode  <= 1'b0;
            r_op    <= '0;
            r_data  <= '0;
            r_id    <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_out1  <= '0;
            r_out2  <= '0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_mode <= w_sel_mode;
                        r_op   <= w_sel_op;
                        r_data <= w_sel_data;
                        r_id   <= w_win;
                        r_gnt0 <= ~w_win;
                        r_gnt1 <= w_win;
                        r_rr   <= ~w_win;
                        if (w_bypass) begin
                            r_state <= ST_RESP;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_out1  <= '0;
                            r_out2  <= '0;
                        end else begin
                            r_state <= ST_EXEC;
                            r_cnt   <= (w_sel_op == OP_DIV) ? c_div_cnt : c_mul_cnt;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_out1  <= w_mu_out1;
                        r_out2  <= w_mu_out2;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_res_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_res_valid = r_valid;
    assign o_res_id    = r_id;
    assign o_res_out1  = r_out1;
    assign o_res_out2  = r_out2;
    assign o_res_err   = r_err;

endmodule
`default_nettype wire
